load_hazard_scoreboard: RTL
===========================

// Module: load_hazard_scoreboard
// PURPOSE
//  Decode-stage hazard detector, the producer-side partner of the EX-stage forwarding unit.
//  Tracks in-flight register writes whose data is not yet forwardable (loads).
//  Stalls the instruction in ID until forwarding can satisfy its rs/rt operands.
//  Drives PC/IF-ID write enables and the ID/EX bubble insert; counts stall cycles.
// PARAMETERS
//  NREG      32  number of architectural registers (r0 hardwired zero)
//  AW        5   register index width, clog2(NREG)
//  LOAD_LAT  1   ID stall cycles needed after a load issues (1..3)
//  CW        2   per-register pending-counter width; must hold LOAD_LAT
//  SCW       16  stall statistics counter width
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     synchronous reset, active low
//  id_valid     in   1     ID stage holds a valid instruction
//  id_rs        in   AW    source register 1 of ID instruction
//  id_rt        in   AW    source register 2 of ID instruction
//  id_uses_rt   in   1     ID instruction reads rt (R-type, store, branch)
//  id_wr_en     in   1     ID instruction writes a register
//  id_rd        in   AW    destination register of ID instruction
//  id_is_load   in   1     ID instruction is a load (lw)
//  flush        in   1     squash ID instruction (branch taken/redirect)
//  stall        out  1     hazard: hold PC and IF/ID this cycle
//  pc_write     out  1     ~stall
//  ifid_write   out  1     ~stall
//  idex_bubble  out  1     stall | flush: load NOP control into ID/EX
//  busy_mask    out  NREG  bit r = register r has a pending non-forwardable write
//  stall_cycles out  SCW   saturating count of cycles with stall=1
// BEHAVIOUR
//  State: pend[r] (CW bits) per register, stall_cycles. pend[0] is always 0.
//  Reset (rst_n=0 at a clk edge): all pend=0 and stall_cycles=0.
//   Outputs are then stall=0, pc_write=1, ifid_write=1, idex_bubble=flush, busy_mask=0.
//   Reset overrides every other event in that cycle, including mid-stall.
//  stall (combinational from registered pend and current ID inputs):
//   stall = id_valid & ~flush & ((id_rs!=0 & pend[id_rs]!=0) | (id_uses_rt & id_rt!=0 & pend[id_rt]!=0)).
//   flush wins over stall: a squashed instruction never stalls.
//  issue = id_valid & ~stall & ~flush.
//  Per-register update, in priority order, each clk:
//   1) r==id_rd, issue, id_wr_en, id_rd!=0, id_is_load -> pend[r] <= LOAD_LAT.
//   2) r==id_rd, issue, id_wr_en, id_rd!=0, ~id_is_load -> pend[r] <= 0.
//      Newer ALU result supersedes the older load for forwarding.
//   3) else pend[r]!=0 -> pend[r] <= pend[r]-1. Never underflows below 0.
//  Counters keep decrementing during stall and flush: in-flight loads progress regardless.
//  A stalled instruction re-evaluates every cycle. With LOAD_LAT=1 a lw followed by a
//   dependent op gives exactly 1 stall cycle; the consumer issues the next cycle.
//  Self-dependence (lw r5,0(r5)): sources are checked against pre-issue pend, so no self-stall.
//  stall_cycles += 1 on each cycle with stall=1; holds at 2^SCW-1 (no wrap).
//  busy_mask[r] = (pend[r]!=0). Registered view; no latency beyond the pend flops.
// TESTING
//  1 lw r8 issues; next cycle add r9,r8,r2 -> stall=1 for 1 cycle, idex_bubble=1; issues cycle 2; stall_cycles=1.
//  2 lw r8; next add r9,r2,r3 (id_uses_rt=1) -> no stall; busy_mask[8]=1 one cycle, then 0.
//  3 lw r0 then add r1,r0,r0 -> pend[0] stays 0, stall=0 throughout.
//  4 lw r8, consumer of r8 in ID with flush=1 -> stall=0, idex_bubble=1; next cycle busy_mask[8]=0.
//  5 LOAD_LAT=2: lw r8 then sw using rt=r8 -> stall=1 for 2 cycles; busy_mask[8] shows 1,1 then 0.
//  6 rst_n=0 during an active stall -> next cycle stall=0, busy_mask=0, stall_cycles=0; saturation at 16'hFFFF holds.

Source files
------------

// File: rtl/load_hazard_scoreboard.sv
// Decode-stage load-use hazard detector: tracks pending load destinations per register,
// stalls ID until forwarding can cover its sources, and counts stall cycles.
module load_hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 2,
    parameter int SCW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_uses_rt,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_is_load,
    input  logic            flush,
    output logic            stall,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            idex_bubble,
    output logic [NREG-1:0] busy_mask,
    output logic [SCW-1:0]  stall_cycles
);

    logic [NREG-1:0][CW-1:0] pend_flat;
    logic [SCW-1:0]          stall_cycles_reg;
    logic [SCW-1:0]          stall_cycles_next;
    logic                    rs_hazard;
    logic                    rt_hazard;
    logic                    issue;
    logic                    issue_write;

    // Sources are compared against pre-issue state, so an instruction never waits on itself.
    assign rs_hazard   = (id_rs != '0) && (pend_flat[id_rs] != '0);
    assign rt_hazard   = id_uses_rt && (id_rt != '0) && (pend_flat[id_rt] != '0);
    assign stall       = id_valid && !flush && (rs_hazard || rt_hazard);
    assign issue       = id_valid && !stall && !flush;
    assign issue_write = issue && id_wr_en && (id_rd != '0);

    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall || flush;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign pend_flat[gi] = '0;
                assign busy_mask[gi] = 1'b0;
            end else begin : g_pend
                logic [CW-1:0] cnt_reg;
                logic [CW-1:0] cnt_next;
                logic          hit;

                assign hit = issue_write && (id_rd == AW'(gi));

                // A newer ALU write clears the entry: its result forwards ahead of the old load.
                always_comb begin
                    cnt_next = cnt_reg;
                    if (hit && id_is_load) begin
                        cnt_next = CW'(LOAD_LAT);
                    end else if (hit) begin
                        cnt_next = '0;
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign pend_flat[gi] = cnt_reg;
                assign busy_mask[gi] = (cnt_reg != '0);
            end
        end
    endgenerate

    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (stall && (stall_cycles_reg != {SCW{1'b1}})) begin
            stall_cycles_next = stall_cycles_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
        end else begin
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule
